binary_game_core: RTL and testbench
===================================

BINARY_GAME_CORE -- requirements
Module: binary_game_core

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles before a switch change is accepted (min 2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000: PLAY cycles allowed per round.
REQ-003 SHALL have parameter RESULT_CYCLES, default 8: cycles the result flags are held.
REQ-004 SHALL have parameter LFSR_SEED, default 8'hA5: nonzero LFSR reset value.
REQ-005 SHALL have port clk  in  1: single clock, all logic on its rising edge.
REQ-006 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-007 SHALL have port ena  in  1: clock enable; low freezes all registers.
REQ-008 SHALL have port sw  in  8: raw DIP switches, asynchronous.
REQ-009 SHALL have port start  in  1: raw start/give-up button, asynchronous, active-high.
REQ-010 SHALL have port target  out  8: number the player must set in binary.
REQ-011 SHALL have port busy  out  1: high in PLAY.
REQ-012 SHALL have port hit  out  1: high in RESULT after a correct answer.
REQ-013 SHALL have port miss  out  1: high in RESULT after a timeout or give-up.
REQ-014 SHALL have port streak  out  4: consecutive correct answers, saturating.
REQ-015 SHALL have port sw_db  out  8: debounced switch value, fed to the display stage.

Function
REQ-016 SHALL pass sw and start through two-flop synchronisers before any other use.
REQ-017 SHALL debounce by holding a candidate value: synced sw differing from the candidate reloads it and clears the counter; once the counter reaches DEBOUNCE_CYCLES-1 with no change, the next edge copies the candidate to sw_db.
REQ-018 SHALL update sw_db on the (DEBOUNCE_CYCLES+3)th rising edge after a raw change held stable; glitches shorter than DEBOUNCE_CYCLES SHALL never reach sw_db.
REQ-019 SHALL detect a start press as synced start high while its previous-cycle value was low, one pulse per press.
REQ-020 SHALL run an 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1, advancing every enabled cycle in all states; it SHALL never hold 0.
REQ-021 SHALL implement FSM states IDLE, PLAY and RESULT.
REQ-022 In IDLE, a start press SHALL latch target <= LFSR value, clear the round timer and enter PLAY on the next edge; busy high 3 edges after the raw rise.
REQ-023 In PLAY, sw_db == target (checked every cycle, including the first) SHALL enter RESULT with hit=1 and streak+1, saturating at 15.
REQ-024 In PLAY, timer == TIMEOUT_CYCLES-1 or a start press SHALL enter RESULT with miss=1 and streak cleared to 0.
REQ-025 Match together with timeout or a start press in the same cycle: the match SHALL win.
REQ-026 In RESULT, hit/miss SHALL hold for exactly RESULT_CYCLES cycles, then the FSM returns to IDLE with both cleared; start presses are ignored.
REQ-027 target SHALL hold its value until the next round is latched; hit and miss SHALL never both be high.
REQ-028 With ena low, all registers, including synchronisers, SHALL hold; no pulse SHALL be lost or duplicated across an ena gap shorter than one press.

Reset
REQ-029 On rst high at a rising edge, regardless of ena or state, the block SHALL reset:
- FSM -> IDLE
- target, sw_db, candidate, synchronisers, counters, timer, streak -> 0
- LFSR -> LFSR_SEED
- busy/hit/miss -> 0
REQ-030 Reset mid-PLAY or mid-RESULT SHALL abort the round with no hit/miss pulse.

Verification (bench parameters: DEBOUNCE=4, TIMEOUT=50, RESULT=8)
REQ-031 Reset, then idle 10 cycles -> all outputs 0, LFSR sequence starts at 8'hA5.
REQ-032 sw 0->8'h3C held, 3-cycle glitch to 8'hFF -> sw_db=8'h3C 7 edges after change, never 8'hFF.
REQ-033 Press start, set sw=target, hold -> hit=1 for 8 cycles, streak=1; repeat 16 rounds -> streak=15.
REQ-034 Press start, never match -> miss after 50 PLAY cycles, streak=0; second press in PLAY -> immediate miss.
REQ-035 Match and give-up press in same PLAY cycle -> hit=1, miss=0; rst mid-PLAY -> IDLE, no pulse, streak=0.
REQ-036 ena low 20 cycles during PLAY -> timer, LFSR and outputs frozen; resume finishes remaining timeout exactly.

Source files
------------

// File: rtl/binary_game_core.sv
// Binary-number guessing game: the player sets DIP switches to match a random target
// before a timeout. Includes input synchronisers, switch debounce, LFSR and round FSM.
module binary_game_core #(
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter int         TIMEOUT_CYCLES  = 1000,
    parameter int         RESULT_CYCLES   = 8,
    parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] sw,
    input  logic       start,
    output logic [7:0] target,
    output logic       busy,
    output logic       hit,
    output logic       miss,
    output logic [3:0] streak,
    output logic [7:0] sw_db
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TM_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RS_W = (RESULT_CYCLES > 2) ? $clog2(RESULT_CYCLES) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TM_W-1:0] TM_LAST = TM_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RS_W-1:0] RS_LAST = RS_W'(RESULT_CYCLES - 1);

    // Galois taps for x^8+x^6+x^5+x^4+1 in right-shift form.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [7:0]      sw_s1;
    logic [7:0]      sw_s2;
    logic            start_s1;
    logic            start_s2;
    logic            start_prev;
    logic            press;

    logic [7:0]      candidate;
    logic [DB_W-1:0] db_cnt;

    logic [7:0]      lfsr;
    logic [7:0]      lfsr_shift;
    logic [7:0]      lfsr_next;

    logic [TM_W-1:0] timer;
    logic [RS_W-1:0] rcnt;
    logic            result_hit;

    logic            match;
    logic            timeout;
    logic            rcnt_last;
    logic            load_round;
    logic            finish_hit;
    logic            finish_miss;
    logic            timer_inc;
    logic            rcnt_inc;

    // Two-flop synchronisers plus the previous synced start for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1      <= '0;
            sw_s2      <= '0;
            start_s1   <= 1'b0;
            start_s2   <= 1'b0;
            start_prev <= 1'b0;
        end else if (ena) begin
            sw_s1      <= sw;
            sw_s2      <= sw_s1;
            start_s1   <= start;
            start_s2   <= start_s1;
            start_prev <= start_s2;
        end
    end

    assign press = start_s2 & ~start_prev;

    // Any change of the synced value restarts the stability count on the new candidate.
    always_ff @(posedge clk) begin
        if (rst) begin
            candidate <= '0;
            db_cnt    <= '0;
            sw_db     <= '0;
        end else if (ena) begin
            if (sw_s2 != candidate) begin
                candidate <= sw_s2;
                db_cnt    <= '0;
            end else if (db_cnt == DB_LAST) begin
                sw_db <= candidate;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign lfsr_shift = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? LFSR_TAPS : 8'h00);
    assign lfsr_next  = (lfsr_shift == 8'h00) ? LFSR_SEED : lfsr_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (ena) begin
            lfsr <= lfsr_next;
        end
    end

    assign match     = (sw_db == target);
    assign timeout   = (timer == TM_LAST);
    assign rcnt_last = (rcnt == RS_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    // A match outranks timeout and give-up when they land in the same cycle.
    always_comb begin
        state_next  = state;
        load_round  = 1'b0;
        finish_hit  = 1'b0;
        finish_miss = 1'b0;
        timer_inc   = 1'b0;
        rcnt_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (press) begin
                    state_next = PLAY;
                    load_round = 1'b1;
                end
            end
            PLAY: begin
                if (match) begin
                    state_next = RESULT;
                    finish_hit = 1'b1;
                end else if (timeout || press) begin
                    state_next  = RESULT;
                    finish_miss = 1'b1;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            RESULT: begin
                if (rcnt_last) begin
                    state_next = IDLE;
                end else begin
                    rcnt_inc = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target     <= '0;
            timer      <= '0;
            rcnt       <= '0;
            result_hit <= 1'b0;
            streak     <= '0;
        end else if (ena) begin
            if (load_round) begin
                target <= lfsr;
                timer  <= '0;
            end
            if (timer_inc) begin
                timer <= timer + 1'b1;
            end
            if (finish_hit || finish_miss) begin
                rcnt       <= '0;
                result_hit <= finish_hit;
            end
            if (rcnt_inc) begin
                rcnt <= rcnt + 1'b1;
            end
            if (finish_hit && (streak != 4'hF)) begin
                streak <= streak + 1'b1;
            end
            if (finish_miss) begin
                streak <= '0;
            end
        end
    end

    assign busy = (state == PLAY);
    assign hit  = (state == RESULT) &  result_hit;
    assign miss = (state == RESULT) & ~result_hit;

endmodule

// File: tb/tb_binary_game_core.sv
// Randomised self-checking bench for binary_game_core against a rule-level reference model
// plus directed scenarios for debounce timing, rounds, give-up, reset and clock-enable gaps.
module tb_binary_game_core;

    localparam int DB = 4;
    localparam int TO = 50;
    localparam int RS = 8;

    localparam int M_IDLE   = 0;
    localparam int M_PLAY   = 1;
    localparam int M_RESULT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] sw;
    logic       start;
    logic [7:0] target;
    logic       busy;
    logic       hit;
    logic       miss;
    logic [3:0] streak;
    logic [7:0] sw_db;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    bit watch_ff = 1'b0;
    bit saw_ff   = 1'b0;

    always #5 clk = ~clk;

    binary_game_core #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TO),
        .RESULT_CYCLES  (RS),
        .LFSR_SEED      (8'hA5)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .sw    (sw),
        .start (start),
        .target(target),
        .busy  (busy),
        .hit   (hit),
        .miss  (miss),
        .streak(streak),
        .sw_db (sw_db)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // LFSR step derived from the polynomial exponents: x^k contributes bit k-1 of the mask.
    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        int         exps[4] = '{8, 6, 5, 4};
        logic [7:0] mask;
        mask = 8'h00;
        foreach (exps[i]) mask = mask | (8'h01 << (exps[i] - 1));
        if (x[0]) return (x >> 1) ^ mask;
        return x >> 1;
    endfunction

    function automatic logic [7:0] lfsr_n(input logic [7:0] seed, input int n);
        logic [7:0] x;
        x = seed;
        for (int i = 0; i < n; i++) x = lfsr_step(x);
        return x;
    endfunction

    // Reference model: raw samples age through two sync stages, the debounced value takes a
    // synced sample once the last DB+1 synced samples agree, and rounds follow the game rules.
    logic [7:0] m_sw_raw [0:1];
    logic       m_st_raw [0:1];
    logic [7:0] m_win    [0:DB];
    logic       m_st_prev;
    logic [7:0] m_db;
    logic [7:0] m_lfsr;
    logic [7:0] m_target;
    int         m_state;
    int         m_timer;
    int         m_rcnt;
    int         m_streak;
    bit         m_hit_flag;

    always @(posedge clk) begin
        logic [7:0] s_sw;
        logic       s_st;
        bit         m_press;
        bit         all_eq;
        if (rst) begin
            m_sw_raw[0] = '0; m_sw_raw[1] = '0;
            m_st_raw[0] = 1'b0; m_st_raw[1] = 1'b0;
            for (int i = 0; i <= DB; i++) m_win[i] = '0;
            m_st_prev  = 1'b0;
            m_db       = '0;
            m_lfsr     = 8'hA5;
            m_target   = '0;
            m_state    = M_IDLE;
            m_timer    = 0;
            m_rcnt     = 0;
            m_streak   = 0;
            m_hit_flag = 1'b0;
        end else if (ena) begin
            s_sw    = m_sw_raw[1];
            s_st    = m_st_raw[1];
            m_press = s_st && !m_st_prev;
            case (m_state)
                M_IDLE: if (m_press) begin
                    m_target = m_lfsr;
                    m_timer  = 0;
                    m_state  = M_PLAY;
                end
                M_PLAY: begin
                    if (m_db == m_target) begin
                        m_state    = M_RESULT;
                        m_hit_flag = 1'b1;
                        m_rcnt     = 0;
                        m_streak   = (m_streak >= 15) ? 15 : m_streak + 1;
                    end else if (m_timer == TO - 1 || m_press) begin
                        m_state    = M_RESULT;
                        m_hit_flag = 1'b0;
                        m_rcnt     = 0;
                        m_streak   = 0;
                    end else begin
                        m_timer++;
                    end
                end
                default: begin
                    if (m_rcnt == RS - 1) m_state = M_IDLE;
                    else m_rcnt++;
                end
            endcase
            for (int i = DB; i > 0; i--) m_win[i] = m_win[i-1];
            m_win[0] = s_sw;
            all_eq = 1'b1;
            for (int i = 1; i <= DB; i++) if (m_win[i] != m_win[0]) all_eq = 1'b0;
            if (all_eq) m_db = m_win[0];
            m_st_prev   = s_st;
            m_sw_raw[1] = m_sw_raw[0]; m_sw_raw[0] = sw;
            m_st_raw[1] = m_st_raw[0]; m_st_raw[0] = start;
            m_lfsr      = lfsr_step(m_lfsr);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("target", target, m_target);
            check("busy", busy, m_state == M_PLAY);
            check("hit", hit, (m_state == M_RESULT) && m_hit_flag);
            check("miss", miss, (m_state == M_RESULT) && !m_hit_flag);
            check("streak", streak, m_streak);
            check("sw_db", sw_db, m_db);
            check("exclusive", hit & miss, 0);
            if (watch_ff && sw_db == 8'hFF) saw_ff = 1'b1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // what: 0 = busy high, 1 = hit or miss high, 2 = all idle
    task automatic wait_dut(input int what, input int budget, input string tag);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        while (n < budget) begin
            case (what)
                0:       ok = busy;
                1:       ok = hit | miss;
                default: ok = !busy && !hit && !miss;
            endcase
            if (ok) break;
            cyc(1);
            n++;
        end
        check({tag, "_wait"}, ok, 1);
    endtask

    task automatic busy_len(output int n);
        n = 1;
        while (n < 200) begin
            cyc(1);
            if (!busy) break;
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp_streak;
        rst = 1'b1; ena = 1'b1; sw = 8'h00; start = 1'b0;
        cyc(3);
        chk_en = 1'b1;
        rst = 1'b0;
        cyc(10);
        check("idle_target", target, 8'h00);
        check("idle_flags", {busy, hit, miss}, 3'b000);
        check("idle_streak", streak, 0);
        check("idle_db", sw_db, 8'h00);

        // First press: busy three edges after the raw rise, target is the seed advanced 12 times.
        start = 1'b1;
        cyc(2);
        check("busy_early", busy, 0);
        cyc(1);
        check("busy_3edges", busy, 1);
        check("first_target", target, lfsr_n(8'hA5, 12));
        start = 1'b0;
        cyc(3);
        start = 1'b1;
        wait_dut(1, 10, "giveup");
        check("giveup_miss", miss, 1);
        start = 1'b0;
        wait_dut(2, 20, "giveup_idle");

        // Debounce latency and glitch rejection.
        sw = 8'h3C;
        cyc(6);
        check("db_before", sw_db, 8'h00);
        cyc(1);
        check("db_after7", sw_db, 8'h3C);
        watch_ff = 1'b1;
        cyc(5);
        sw = 8'hFF;
        cyc(3);
        sw = 8'h3C;
        cyc(15);
        watch_ff = 1'b0;
        check("glitch_blocked", saw_ff, 0);
        check("db_hold", sw_db, 8'h3C);

        // Sixteen winning rounds drive the streak into saturation.
        for (int r = 0; r < 16; r++) begin
            sw = 8'($urandom_range(0, 255));
            cyc($urandom_range(1, 8));
            start = 1'b1;
            wait_dut(0, 10, "hit_busy");
            start = 1'b0;
            cyc($urandom_range(0, 3));
            sw = m_target;
            wait_dut(1, 40, "hit_result");
            check("hit_flag", hit, 1);
            n = 1;
            while (n < 20) begin
                cyc(1);
                if (!hit) break;
                n++;
            end
            check("hit_len", n, RS);
            wait_dut(2, 10, "hit_idle");
            exp_streak = (r + 1 > 15) ? 15 : r + 1;
            check("streak_round", streak, exp_streak);
        end
        check("streak_sat", streak, 15);

        // Timeout round: sw 0 can never equal a nonzero LFSR target.
        sw = 8'h00;
        cyc(8);
        start = 1'b1;
        wait_dut(0, 10, "to_busy");
        start = 1'b0;
        busy_len(n);
        check("timeout_len", n, TO);
        check("timeout_miss", miss, 1);
        check("timeout_streak", streak, 0);
        wait_dut(2, 20, "to_idle");

        // Match and give-up press reach the FSM on the same edge.
        start = 1'b1;
        wait_dut(0, 10, "sim_busy");
        start = 1'b0;
        cyc(2);
        sw = m_target;
        cyc(5);
        start = 1'b1;
        cyc(4);
        start = 1'b0;
        check("sim_hit", hit, 1);
        check("sim_miss", miss, 0);
        check("sim_streak", streak, 1);
        wait_dut(2, 20, "sim_idle");

        // Reset in the middle of a round.
        sw = 8'h00;
        cyc(8);
        start = 1'b1;
        wait_dut(0, 10, "rst_busy");
        start = 1'b0;
        cyc(5);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("rst_busy_clr", busy, 0);
        check("rst_flags", {hit, miss}, 2'b00);
        check("rst_streak", streak, 0);
        check("rst_target", target, 8'h00);
        cyc(15);

        // Clock-enable gap inside PLAY stretches the round by exactly the gap length.
        start = 1'b1;
        wait_dut(0, 10, "ena_busy");
        start = 1'b0;
        cyc(9);
        ena = 1'b0;
        cyc(20);
        check("ena_frozen_busy", busy, 1);
        ena = 1'b1;
        n = 30;
        while (n < 200) begin
            cyc(1);
            if (!busy) break;
            n++;
        end
        check("ena_play_len", n, TO + 20);
        check("ena_miss", miss, 1);
        wait_dut(2, 20, "ena_idle");
        start = 1'b1;
        wait_dut(0, 10, "post_ena_busy");
        start = 1'b0;
        wait_dut(1, 80, "post_ena_result");
        wait_dut(2, 20, "post_ena_idle");

        // Random soak: enable gaps, switch churn, start toggles, one reset.
        for (int i = 0; i < 600; i++) begin
            ena = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 9))
                0:       sw = 8'($urandom_range(0, 255));
                1:       sw = m_target;
                2:       start = ~start;
                default: ;
            endcase
            rst = (i == 300);
            cyc(1);
        end
        rst = 1'b0; ena = 1'b1; start = 1'b0;
        cyc(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
